// File: rtl/ccu_layer_seq_if.sv
// ccu_layer_seq_if
// Configuration bus between the network configuration source and the CCU
// layer sequencer.
//
// Signals:
//   CFG_Val     config valid (master -> slave)
//   CFG_NumLay  layers in the network (LAY_W)
//   CFG_NumFrm  frames per layer (FRM_W)
//   CFG_NumPat  patches per frame (PAT_W)
//   CFG_Rdy     slave is idle and can take a configuration
//   CFG_Err     1-cycle pulse, configuration rejected (a count was zero)
//
// Modports: master drives the request, slave (the sequencer) answers.
interface ccu_layer_seq_if #(
  parameter int LAY_W = 6,
  parameter int FRM_W = 8,
  parameter int PAT_W = 8
);
  logic             CFG_Val;
  logic [LAY_W-1:0] CFG_NumLay;
  logic [FRM_W-1:0] CFG_NumFrm;
  logic [PAT_W-1:0] CFG_NumPat;
  logic             CFG_Rdy;
  logic             CFG_Err;

  modport master (
    output CFG_Val, CFG_NumLay, CFG_NumFrm, CFG_NumPat,
    input  CFG_Rdy, CFG_Err
  );

  modport slave (
    input  CFG_Val, CFG_NumLay, CFG_NumFrm, CFG_NumPat,
    output CFG_Rdy, CFG_Err
  );
endinterface

// File: rtl/ccu_layer_seq.sv
// ccu_layer_seq
// Network / layer / frame / patch sequencer for the CCU compute phase.
// Latches a network configuration, waits for the global buffer at the start
// of each layer, issues one TOP_Sta pulse per patch and walks the
// patch/frame/layer indices, emitting layer-reset, frame-finish and
// network-done pulses.
//
// Optional feature: define LAYSEQ_WDT_EN to build a RUN-state watchdog.
// Without it no counter exists and Wdt_Err is tied low.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cfg             configuration bus (slave side of ccu_layer_seq_if)
//   GBF_Val         global buffer holds the current layer
//   CTRLACT_FnhPat  1-cycle pulse: patch computation finished
//   TOP_Sta         1-cycle pulse: start one patch
//   Rst_Layer       1-cycle pulse: new layer begins
//   Fnh_Frm         1-cycle pulse: frame completed
//   Net_Done        1-cycle pulse: network completed
//   Cur_Lay/Frm/Pat current indices (registered)
//   Wdt_Err         sticky watchdog error
module ccu_layer_seq #(
  parameter int               LAY_W     = 6,
  parameter int               FRM_W     = 8,
  parameter int               PAT_W     = 8,
  parameter int               WDT_W     = 16,
  parameter logic [WDT_W-1:0] WDT_LIMIT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  ccu_layer_seq_if.slave   cfg,
  input  logic             GBF_Val,
  input  logic             CTRLACT_FnhPat,
  output logic             TOP_Sta,
  output logic             Rst_Layer,
  output logic             Fnh_Frm,
  output logic             Net_Done,
  output logic [LAY_W-1:0] Cur_Lay,
  output logic [FRM_W-1:0] Cur_Frm,
  output logic [PAT_W-1:0] Cur_Pat,
  output logic             Wdt_Err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAITGBF = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [LAY_W-1:0] num_lay, num_lay_d, lay_d;
  logic [FRM_W-1:0] num_frm, num_frm_d, frm_d;
  logic [PAT_W-1:0] num_pat, num_pat_d, pat_d;
  logic             rst_layer_d, fnh_frm_d, cfg_err_d, cfg_err_q;

  logic cfg_zero, cfg_acc, cfg_rej, fin;
  logic last_pat, last_frm, last_lay;
  logic wdt_trip;

  assign cfg_zero = (cfg.CFG_NumLay == '0) || (cfg.CFG_NumFrm == '0) ||
                    (cfg.CFG_NumPat == '0);
  assign cfg_acc  = (state == S_IDLE) && cfg.CFG_Val && !cfg_zero;
  assign cfg_rej  = (state == S_IDLE) && cfg.CFG_Val &&  cfg_zero;
  // Finish pulses outside RUN (including in START) are simply dropped.
  assign fin      = (state == S_RUN) && CTRLACT_FnhPat;

  assign last_pat = (Cur_Pat == num_pat - PAT_W'(1));
  assign last_frm = (Cur_Frm == num_frm - FRM_W'(1));
  assign last_lay = (Cur_Lay == num_lay - LAY_W'(1));

  assign cfg.CFG_Rdy = (state == S_IDLE);
  assign cfg.CFG_Err = cfg_err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (cfg_acc) state_nxt = S_WAITGBF;
      S_WAITGBF: if (GBF_Val) state_nxt = S_START;
      S_START:   state_nxt = S_RUN;
      S_RUN: begin
        if (fin) begin
          if (!last_pat || !last_frm) state_nxt = S_START;
          else if (!last_lay)         state_nxt = S_WAITGBF;
          else                        state_nxt = S_DONE;
        end else if (wdt_trip) begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; registered below so every pulse and
  // index appears one cycle after the event that caused it.
  always_comb begin
    num_lay_d   = num_lay;
    num_frm_d   = num_frm;
    num_pat_d   = num_pat;
    lay_d       = Cur_Lay;
    frm_d       = Cur_Frm;
    pat_d       = Cur_Pat;
    rst_layer_d = 1'b0;
    fnh_frm_d   = 1'b0;
    cfg_err_d   = cfg_rej;
    if (cfg_acc) begin
      num_lay_d   = cfg.CFG_NumLay;
      num_frm_d   = cfg.CFG_NumFrm;
      num_pat_d   = cfg.CFG_NumPat;
      lay_d       = '0;
      frm_d       = '0;
      pat_d       = '0;
      rst_layer_d = 1'b1;
    end
    if (fin) begin
      if (!last_pat) begin
        pat_d = Cur_Pat + PAT_W'(1);
      end else if (!last_frm) begin
        pat_d     = '0;
        frm_d     = Cur_Frm + FRM_W'(1);
        fnh_frm_d = 1'b1;
      end else if (!last_lay) begin
        pat_d       = '0;
        frm_d       = '0;
        lay_d       = Cur_Lay + LAY_W'(1);
        fnh_frm_d   = 1'b1;
        rst_layer_d = 1'b1;
      end else begin
        // Final patch: indices keep their last values until the next config.
        fnh_frm_d = 1'b1;
      end
    end else if (wdt_trip) begin
      lay_d = '0;
      frm_d = '0;
      pat_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lay   <= '0;
      num_frm   <= '0;
      num_pat   <= '0;
      Cur_Lay   <= '0;
      Cur_Frm   <= '0;
      Cur_Pat   <= '0;
      TOP_Sta   <= 1'b0;
      Rst_Layer <= 1'b0;
      Fnh_Frm   <= 1'b0;
      Net_Done  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      num_lay   <= num_lay_d;
      num_frm   <= num_frm_d;
      num_pat   <= num_pat_d;
      Cur_Lay   <= lay_d;
      Cur_Frm   <= frm_d;
      Cur_Pat   <= pat_d;
      // START and DONE each last one cycle, so these are exact pulses.
      TOP_Sta   <= (state_nxt == S_START);
      Rst_Layer <= rst_layer_d;
      Fnh_Frm   <= fnh_frm_d;
      Net_Done  <= (state_nxt == S_DONE);
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef LAYSEQ_WDT_EN
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_err_q;

  // START always precedes RUN, so clearing in START zeroes the count on
  // the first RUN cycle. Trip when the count is about to reach the limit,
  // so the error appears exactly WDT_LIMIT cycles after RUN entry. A
  // finish in that same cycle takes priority.
  assign wdt_trip = (state == S_RUN) && !CTRLACT_FnhPat &&
                    (wdt_cnt == WDT_LIMIT - WDT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt   <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      if (state == S_START)    wdt_cnt <= '0;
      else if (state == S_RUN) wdt_cnt <= wdt_cnt + WDT_W'(1);
      if (cfg_acc)       wdt_err_q <= 1'b0;
      else if (wdt_trip) wdt_err_q <= 1'b1;
    end
  end

  assign Wdt_Err = wdt_err_q;
`else
  assign wdt_trip = 1'b0;
  assign Wdt_Err  = 1'b0;
`endif

endmodule

// File: tb/tb_ccu_layer_seq.sv
// tb_ccu_layer_seq
// Scoreboard bench for ccu_layer_seq. Stimulus pushes the expected pulse
// events (pulse flags plus indices) into a queue; a monitor pops and
// compares each time the DUT raises any pulse output. Level checks are
// made directly from the stimulus thread.
module tb_ccu_layer_seq;

  localparam int LAY_W = 6;
  localparam int FRM_W = 8;
  localparam int PAT_W = 8;
`ifdef LAYSEQ_WDT_EN
  localparam logic [15:0] TB_WDT_LIMIT = 16'd20;
`else
  localparam logic [15:0] TB_WDT_LIMIT = 16'hFFFF;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             GBF_Val;
  logic             CTRLACT_FnhPat;
  logic             TOP_Sta, Rst_Layer, Fnh_Frm, Net_Done, Wdt_Err;
  logic [LAY_W-1:0] Cur_Lay;
  logic [FRM_W-1:0] Cur_Frm;
  logic [PAT_W-1:0] Cur_Pat;

  always #5 clk = ~clk;

  ccu_layer_seq_if #(.LAY_W(LAY_W), .FRM_W(FRM_W), .PAT_W(PAT_W)) cfg_if ();

  ccu_layer_seq #(
    .LAY_W(LAY_W), .FRM_W(FRM_W), .PAT_W(PAT_W),
    .WDT_W(16), .WDT_LIMIT(TB_WDT_LIMIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg_if),
    .GBF_Val       (GBF_Val),
    .CTRLACT_FnhPat(CTRLACT_FnhPat),
    .TOP_Sta       (TOP_Sta),
    .Rst_Layer     (Rst_Layer),
    .Fnh_Frm       (Fnh_Frm),
    .Net_Done      (Net_Done),
    .Cur_Lay       (Cur_Lay),
    .Cur_Frm       (Cur_Frm),
    .Cur_Pat       (Cur_Pat),
    .Wdt_Err       (Wdt_Err)
  );

  typedef struct packed {
    logic       top;
    logic       fnh;
    logic       rst;
    logic       done;
    logic       err;
    logic [5:0] lay;
    logic [7:0] frm;
    logic [7:0] pat;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic ev_t mk(input bit t, input bit f, input bit r,
                             input bit d, input bit e,
                             input int l, input int fr, input int p);
    ev_t v;
    v.top = t; v.fnh = f; v.rst = r; v.done = d; v.err = e;
    v.lay = l[5:0]; v.frm = fr[7:0]; v.pat = p[7:0];
    return v;
  endfunction

  task automatic push(input bit t, input bit f, input bit r, input bit d,
                      input bit e, input int l, input int fr, input int p);
    sb.push_back(mk(t, f, r, d, e, l, fr, p));
  endtask

  // Expected event list for Lay=2, Frm=2, Pat=3 (hand-derived).
  task automatic push_basic(input int n);
    ev_t t[15];
    t[0]  = mk(0,0,1,0,0, 0,0,0);  // accept: Rst_Layer
    t[1]  = mk(1,0,0,0,0, 0,0,0);
    t[2]  = mk(1,0,0,0,0, 0,0,1);
    t[3]  = mk(1,0,0,0,0, 0,0,2);
    t[4]  = mk(1,1,0,0,0, 0,1,0);  // frame 0 done, next patch starts
    t[5]  = mk(1,0,0,0,0, 0,1,1);
    t[6]  = mk(1,0,0,0,0, 0,1,2);
    t[7]  = mk(0,1,1,0,0, 1,0,0);  // layer 0 done
    t[8]  = mk(1,0,0,0,0, 1,0,0);
    t[9]  = mk(1,0,0,0,0, 1,0,1);
    t[10] = mk(1,0,0,0,0, 1,0,2);
    t[11] = mk(1,1,0,0,0, 1,1,0);
    t[12] = mk(1,0,0,0,0, 1,1,1);
    t[13] = mk(1,0,0,0,0, 1,1,2);
    t[14] = mk(0,1,0,1,0, 1,1,2);  // last frame + network done
    for (int i = 0; i < n; i++) sb.push_back(t[i]);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_send(input int l, input int f, input int p);
    cfg_if.CFG_Val    = 1'b1;
    cfg_if.CFG_NumLay = l[LAY_W-1:0];
    cfg_if.CFG_NumFrm = f[FRM_W-1:0];
    cfg_if.CFG_NumPat = p[PAT_W-1:0];
    step();
    cfg_if.CFG_Val = 1'b0;
  endtask

  task automatic wait_top();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (TOP_Sta === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_top: got no TOP_Sta within 60 cycles, expected one");
    end
  endtask

  // Finish the current patch 3 cycles after its TOP_Sta.
  task automatic run_patch();
    wait_top();
    repeat (2) step();
    CTRLACT_FnhPat = 1'b1;
    step();
    CTRLACT_FnhPat = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    ev_t act, exp;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 &&
          (TOP_Sta || Fnh_Frm || Rst_Layer || Net_Done || cfg_if.CFG_Err)) begin
        act = '{top: TOP_Sta, fnh: Fnh_Frm, rst: Rst_Layer, done: Net_Done,
                err: cfg_if.CFG_Err, lay: Cur_Lay, frm: Cur_Frm, pat: Cur_Pat};
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL pulse_ev: got unexpected sta/fnh/rst/done/err=%b%b%b%b%b idx=%0d.%0d.%0d, expected no pulse",
                   act.top, act.fnh, act.rst, act.done, act.err, act.lay, act.frm, act.pat);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL pulse_ev: got sta/fnh/rst/done/err=%b%b%b%b%b idx=%0d.%0d.%0d, expected %b%b%b%b%b idx=%0d.%0d.%0d",
                     act.top, act.fnh, act.rst, act.done, act.err, act.lay, act.frm, act.pat,
                     exp.top, exp.fnh, exp.rst, exp.done, exp.err, exp.lay, exp.frm, exp.pat);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b0;
    GBF_Val           = 1'b0;
    CTRLACT_FnhPat    = 1'b0;
    cfg_if.CFG_Val    = 1'b0;
    cfg_if.CFG_NumLay = '0;
    cfg_if.CFG_NumFrm = '0;
    cfg_if.CFG_NumPat = '0;
    repeat (3) step();

    // Reset state
    chk("rst_cfg_rdy", int'(cfg_if.CFG_Rdy), 1);
    chk("rst_wdt_err", int'(Wdt_Err), 0);
    chk("rst_pulses", int'({TOP_Sta, Rst_Layer, Fnh_Frm, Net_Done, cfg_if.CFG_Err}), 0);
    chk("rst_idx", int'({Cur_Lay, Cur_Frm, Cur_Pat}), 0);
    rst_n = 1'b1;
    step();

    // Basic sequence: Lay=2 Frm=2 Pat=3, GBF held high
    push_basic(15);
    GBF_Val = 1'b1;
    cfg_send(2, 2, 3);
    chk("basic_busy", int'(cfg_if.CFG_Rdy), 0);
    repeat (12) run_patch();
    step();
    chk("basic_rdy_end", int'(cfg_if.CFG_Rdy), 1);
    chk("basic_sb_empty", sb.size(), 0);
    chk("basic_idx_hold", int'({Cur_Lay, Cur_Frm, Cur_Pat}), int'({6'd1, 8'd1, 8'd2}));

    // Zero count: rejected, indices and state unchanged
    push(0,0,0,0,1, 1,1,2);
    cfg_send(2, 0, 3);
    chk("zero_rdy", int'(cfg_if.CFG_Rdy), 1);
    chk("zero_no_rstlay", int'(Rst_Layer), 0);
    step();
    chk("zero_sb_empty", sb.size(), 0);

    // GBF stall: Lay=2 Frm=1 Pat=1
    push(0,0,1,0,0, 0,0,0);
    push(1,0,0,0,0, 0,0,0);
    push(0,1,1,0,0, 1,0,0);
    push(1,0,0,0,0, 1,0,0);
    push(0,1,0,1,0, 1,0,0);
    cfg_send(2, 1, 1);
    wait_top();
    GBF_Val = 1'b0;
    repeat (2) step();
    CTRLACT_FnhPat = 1'b1;
    step();
    CTRLACT_FnhPat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_no_sta", int'(TOP_Sta), 0);
    end
    GBF_Val = 1'b1;
    step();
    chk("stall_sta_after_gbf", int'(TOP_Sta), 1);
    run_patch();
    step();
    chk("stall_rdy_end", int'(cfg_if.CFG_Rdy), 1);
    chk("stall_sb_empty", sb.size(), 0);

    // Ignored inputs: Lay=1 Frm=1 Pat=2
    GBF_Val = 1'b0;
    push(0,0,1,0,0, 0,0,0);
    push(1,0,0,0,0, 0,0,0);
    push(1,0,0,0,0, 0,0,1);
    push(0,1,0,1,0, 0,0,1);
    cfg_send(1, 1, 2);
    CTRLACT_FnhPat = 1'b1;          // stray finish in WAITGBF
    step();
    CTRLACT_FnhPat = 1'b0;
    chk("ign_wait_pat", int'(Cur_Pat), 0);
    chk("ign_wait_busy", int'(cfg_if.CFG_Rdy), 0);
    GBF_Val = 1'b1;
    step();                         // now in START
    GBF_Val = 1'b0;
    CTRLACT_FnhPat = 1'b1;          // finish during START is dropped
    step();
    CTRLACT_FnhPat = 1'b0;
    chk("ign_start_pat", int'(Cur_Pat), 0);
    cfg_if.CFG_Val    = 1'b1;       // config during RUN is ignored
    cfg_if.CFG_NumLay = 6'd3;
    cfg_if.CFG_NumFrm = 8'd3;
    cfg_if.CFG_NumPat = 8'd3;
    step();
    cfg_if.CFG_Val = 1'b0;
    chk("ign_run_idx", int'({Cur_Lay, Cur_Frm, Cur_Pat}), 0);
    chk("ign_run_busy", int'(cfg_if.CFG_Rdy), 0);
    CTRLACT_FnhPat = 1'b1;
    step();
    CTRLACT_FnhPat = 1'b0;
    chk("ign_pat_adv", int'(Cur_Pat), 1);
    run_patch();
    step();
    chk("ign_rdy_end", int'(cfg_if.CFG_Rdy), 1);
    chk("ign_sb_empty", sb.size(), 0);

    // Reset mid-run at Lay=1 Frm=1 Pat=2
    GBF_Val = 1'b1;
    push_basic(14);
    cfg_send(2, 2, 3);
    repeat (11) run_patch();
    wait_top();
    step();
    chk("mid_idx", int'({Cur_Lay, Cur_Frm, Cur_Pat}), int'({6'd1, 8'd1, 8'd2}));
    chk("mid_busy", int'(cfg_if.CFG_Rdy), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", int'(cfg_if.CFG_Rdy), 1);
    chk("mid_rst_idx", int'({Cur_Lay, Cur_Frm, Cur_Pat}), 0);
    chk("mid_rst_pulses", int'({TOP_Sta, Rst_Layer, Fnh_Frm, Net_Done, cfg_if.CFG_Err}), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_stays_idle", int'(cfg_if.CFG_Rdy), 1);
    chk("mid_sb_empty", sb.size(), 0);

`ifdef LAYSEQ_WDT_EN
    // Watchdog: Lay=Frm=Pat=1, finish withheld
    push(0,0,1,0,0, 0,0,0);
    push(1,0,0,0,0, 0,0,0);
    cfg_send(1, 1, 1);
    wait_top();
    repeat (20) @(negedge clk);
    chk("wdt_not_yet", int'(Wdt_Err), 0);
    chk("wdt_still_run", int'(cfg_if.CFG_Rdy), 0);
    @(negedge clk);
    chk("wdt_err_set", int'(Wdt_Err), 1);
    chk("wdt_idle", int'(cfg_if.CFG_Rdy), 1);
    chk("wdt_idx_clr", int'({Cur_Lay, Cur_Frm, Cur_Pat}), 0);
    push(0,0,1,0,0, 0,0,0);
    push(1,0,0,0,0, 0,0,0);
    push(0,1,0,1,0, 0,0,0);
    step();
    cfg_send(1, 1, 1);
    chk("wdt_err_cleared", int'(Wdt_Err), 0);
    run_patch();
    step();
    chk("wdt_rdy_end", int'(cfg_if.CFG_Rdy), 1);
    chk("wdt_sb_empty", sb.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
